// File: rtl/sha_256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha_256_round_ctrl
//
// Sequencing controller for one SHA-256 compression of a 512-bit block.
// After a start handshake it walks through INIT (load working variables),
// NUM_ROUNDS rounds (stallable through hold_i), FINAL (hash update) and
// DONE (one-cycle completion pulse), then returns to IDLE.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_valid_i  request to compress the presented block
//   start_ready_o  high only in IDLE (decoded from state)
//   init_i         sampled with start: 1 = first block (IV), 0 = chain
//   hold_i         datapath stall request, honoured in ROUND only
//   abort_i        synchronous cancel from INIT, ROUND or FINAL
//   round_idx_o    current round, drives the constants index
//   round_en_o     datapath performs one round this cycle
//   round_last_o   round_en_o high on the final round (decoded)
//   w_sel_sched_o  W comes from the schedule recurrence
//   ld_state_o     load a..h from H (or IV)
//   sel_iv_o       with ld_state_o: 1 = load the IV constants
//   upd_hash_o     H += a..h this cycle
//   busy_o         controller is not IDLE
//   done_o         one-cycle pulse when the digest has been updated
//   blk_cnt_o      blocks completed since the last init=1 block
// ---------------------------------------------------------------------------
module sha_256_round_ctrl #(
    parameter int NUM_ROUNDS  = 64,
    parameter int SCHED_START = 16,
    parameter int IDX_W       = 7,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             init_i,
    input  logic             hold_i,
    input  logic             abort_i,
    output logic [IDX_W-1:0] round_idx_o,
    output logic             round_en_o,
    output logic             round_last_o,
    output logic             w_sel_sched_o,
    output logic             ld_state_o,
    output logic             sel_iv_o,
    output logic             upd_hash_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] SCHED_IDX = IDX_W'(SCHED_START);

    state_e           state_q;
    logic             init_q;
    logic [IDX_W-1:0] round_idx_q;
    logic [IDX_W-1:0] round_idx_d;
    logic             w_sel_sched_q;
    logic             ld_state_q;
    logic             sel_iv_q;
    logic             upd_hash_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             round_en;
    logic             at_last;

    // round_en must react to hold_i in the same cycle, so it is decoded from
    // the registered state rather than registered itself.
    assign round_en = (state_q == S_ROUND) && !hold_i;
    assign at_last  = (round_idx_q == LAST_IDX);

    // The index is zero outside ROUND; abort overrides both hold and advance,
    // and the last round wraps to 0 so NUM_ROUNDS is never presented.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        round_idx_d = round_idx_q;
        if ((state_q != S_ROUND) || abort_i) begin
            round_idx_d = '0;
        end else if (round_en) begin
            round_idx_d = at_last ? '0 : round_idx_q + IDX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            init_q        <= 1'b0;
            round_idx_q   <= '0;
            w_sel_sched_q <= 1'b0;
            ld_state_q    <= 1'b0;
            sel_iv_q      <= 1'b0;
            upd_hash_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            blk_cnt_q     <= '0;
        end else begin
            round_idx_q   <= round_idx_d;
            // Registered alongside the index so it stays valid during hold.
            w_sel_sched_q <= (round_idx_d >= SCHED_IDX);
            unique case (state_q)
                S_IDLE: begin
                    if (start_valid_i) begin
                        state_q    <= S_INIT;
                        init_q     <= init_i;
                        ld_state_q <= 1'b1;
                        sel_iv_q   <= init_i;
                        busy_q     <= 1'b1;
                    end
                end
                S_INIT: begin
                    ld_state_q <= 1'b0;
                    sel_iv_q   <= 1'b0;
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_ROUND;
                        if (init_q) begin
                            blk_cnt_q <= '0;
                        end
                    end
                end
                S_ROUND: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (round_en && at_last) begin
                        state_q    <= S_FINAL;
                        upd_hash_q <= 1'b1;
                    end
                end
                S_FINAL: begin
                    // The upd_hash strobe of this cycle has already reached
                    // the datapath; abort only suppresses count and done.
                    upd_hash_q <= 1'b0;
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= S_DONE;
                        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready_o = (state_q == S_IDLE);
    assign round_en_o    = round_en;
    assign round_last_o  = round_en && at_last;
    assign round_idx_o   = round_idx_q;
    assign w_sel_sched_o = w_sel_sched_q;
    assign ld_state_o    = ld_state_q;
    assign sel_iv_o      = sel_iv_q;
    assign upd_hash_o    = upd_hash_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign blk_cnt_o     = blk_cnt_q;

endmodule

// File: tb/tb_sha_256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha_256_round_ctrl
//
// Drives whole-block transactions with random hold/start/abort noise and
// compares every cycle against expectations built from round counting:
// the handshake cycle is followed by one load cycle, NUM_ROUNDS unstalled
// round cycles (index = rounds completed so far), one update cycle and one
// done cycle. A second instance with NUM_ROUNDS=20 is checked against a
// fixed cycle timeline.
// ---------------------------------------------------------------------------
module tb_sha_256_round_ctrl;

    localparam int NR    = 64;
    localparam int SS    = 16;
    localparam int IDX_W = 7;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic             init;
    logic             hold;
    logic             abort;
    logic [IDX_W-1:0] round_idx;
    logic             round_en;
    logic             round_last;
    logic             w_sel_sched;
    logic             ld_state;
    logic             sel_iv;
    logic             upd_hash;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] blk_cnt;

    logic             sv20;
    logic             sr20;
    logic             init20;
    logic             hold20;
    logic             abort20;
    logic [IDX_W-1:0] idx20;
    logic             en20;
    logic             last20;
    logic             wsel20;
    logic             ld20;
    logic             iv20;
    logic             upd20;
    logic             busy20;
    logic             done20;
    logic [CNT_W-1:0] cnt20;

    int checks;
    int failures;
    int exp_blk;

    sha_256_round_ctrl #(
        .NUM_ROUNDS (NR),
        .SCHED_START(SS),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid_i(start_valid),
        .start_ready_o(start_ready),
        .init_i       (init),
        .hold_i       (hold),
        .abort_i      (abort),
        .round_idx_o  (round_idx),
        .round_en_o   (round_en),
        .round_last_o (round_last),
        .w_sel_sched_o(w_sel_sched),
        .ld_state_o   (ld_state),
        .sel_iv_o     (sel_iv),
        .upd_hash_o   (upd_hash),
        .busy_o       (busy),
        .done_o       (done),
        .blk_cnt_o    (blk_cnt)
    );

    sha_256_round_ctrl #(
        .NUM_ROUNDS (20),
        .SCHED_START(16),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) dut20 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid_i(sv20),
        .start_ready_o(sr20),
        .init_i       (init20),
        .hold_i       (hold20),
        .abort_i      (abort20),
        .round_idx_o  (idx20),
        .round_en_o   (en20),
        .round_last_o (last20),
        .w_sel_sched_o(wsel20),
        .ld_state_o   (ld20),
        .sel_iv_o     (iv20),
        .upd_hash_o   (upd20),
        .busy_o       (busy20),
        .done_o       (done20),
        .blk_cnt_o    (cnt20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"},   32'(round_idx), 0);
        check({tag, "_en"},    32'(round_en), 0);
        check({tag, "_last"},  32'(round_last), 0);
        check({tag, "_wsel"},  32'(w_sel_sched), 0);
        check({tag, "_ld"},    32'(ld_state), 0);
        check({tag, "_iv"},    32'(sel_iv), 0);
        check({tag, "_upd"},   32'(upd_hash), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_cnt"},   32'(blk_cnt), 0);
        check({tag, "_ready"}, 32'(start_ready), 1);
    endtask

    // One block transaction. abort_round / reset_round of -1 means never.
    task automatic run_block(input bit ini, input int hold_pct,
                             input int stall_at, input int stall_len,
                             input int abort_round, input bit abort_final,
                             input bit abort_at_start, input int reset_round);
        int r;
        int stall_left;
        bit h;
        bit a;

        // Handshake cycle (IDLE); abort here must not block the start.
        @(negedge clk);
        start_valid = 1'b1;
        init        = ini;
        hold        = 1'($urandom_range(1, 0));
        abort       = abort_at_start;
        #1;
        check("idle_ready", 32'(start_ready), 1);
        check("idle_busy",  32'(busy), 0);
        check("idle_done",  32'(done), 0);

        // INIT cycle; start_valid noise must be ignored from here on.
        @(negedge clk);
        start_valid = 1'($urandom_range(1, 0));
        init        = ~ini;
        hold        = 1'($urandom_range(1, 0));
        abort       = 1'b0;
        #1;
        check("init_ld",    32'(ld_state), 1);
        check("init_iv",    32'(sel_iv), 32'(ini));
        check("init_idx",   32'(round_idx), 0);
        check("init_en",    32'(round_en), 0);
        check("init_busy",  32'(busy), 1);
        check("init_ready", 32'(start_ready), 0);
        if (ini) exp_blk = 0;

        r = 0;
        stall_left = stall_len;
        while (r < NR) begin
            @(negedge clk);
            if (r == stall_at && stall_left > 0) begin
                h = 1'b1;
                stall_left--;
            end else begin
                h = ($urandom_range(99, 0) < hold_pct);
            end
            a = (r == abort_round);
            start_valid = 1'($urandom_range(1, 0));
            hold        = h;
            abort       = a;
            #1;
            check("rnd_idx",  32'(round_idx), 32'(r));
            check("rnd_en",   32'(round_en), 32'(!h));
            check("rnd_last", 32'(round_last), 32'(!h && r == NR - 1));
            check("rnd_wsel", 32'(w_sel_sched), 32'(r >= SS));
            check("rnd_ld",   32'(ld_state), 0);
            check("rnd_upd",  32'(upd_hash), 0);
            check("rnd_done", 32'(done), 0);
            check("rnd_busy", 32'(busy), 1);
            check("rnd_cnt",  32'(blk_cnt), 32'(exp_blk));
            if (r == reset_round) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                rst_n       = 1'b1;
                start_valid = 1'b0;
                hold        = 1'b0;
                abort       = 1'b0;
                #1;
                check("postrst_ready", 32'(start_ready), 1);
                exp_blk = 0;
                return;
            end
            if (a) begin
                @(negedge clk);
                start_valid = 1'b0;
                hold        = 1'b0;
                abort       = 1'b0;
                #1;
                check("abr_idx",   32'(round_idx), 0);
                check("abr_busy",  32'(busy), 0);
                check("abr_ready", 32'(start_ready), 1);
                check("abr_upd",   32'(upd_hash), 0);
                check("abr_done",  32'(done), 0);
                check("abr_cnt",   32'(blk_cnt), 32'(exp_blk));
                return;
            end
            if (h) begin
                // stalled: index must stay put
            end else begin
                r++;
            end
        end

        // FINAL cycle: hold is ignored here.
        @(negedge clk);
        start_valid = 1'($urandom_range(1, 0));
        hold        = 1'($urandom_range(1, 0));
        abort       = abort_final;
        #1;
        check("fin_upd",  32'(upd_hash), 1);
        check("fin_en",   32'(round_en), 0);
        check("fin_last", 32'(round_last), 0);
        check("fin_idx",  32'(round_idx), 0);
        check("fin_done", 32'(done), 0);
        check("fin_busy", 32'(busy), 1);
        if (abort_final) begin
            @(negedge clk);
            start_valid = 1'b0;
            hold        = 1'b0;
            abort       = 1'b0;
            #1;
            check("abrf_busy",  32'(busy), 0);
            check("abrf_done",  32'(done), 0);
            check("abrf_upd",   32'(upd_hash), 0);
            check("abrf_ready", 32'(start_ready), 1);
            check("abrf_cnt",   32'(blk_cnt), 32'(exp_blk));
            return;
        end
        exp_blk = (exp_blk + 1) % (1 << CNT_W);

        // DONE cycle: start/abort noise ignored.
        @(negedge clk);
        start_valid = 1'($urandom_range(1, 0));
        hold        = 1'($urandom_range(1, 0));
        abort       = 1'($urandom_range(1, 0));
        #1;
        check("dn_done",  32'(done), 1);
        check("dn_busy",  32'(busy), 1);
        check("dn_ready", 32'(start_ready), 0);
        check("dn_upd",   32'(upd_hash), 0);
        check("dn_cnt",   32'(blk_cnt), 32'(exp_blk));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_blk     = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        init        = 1'b0;
        hold        = 1'b0;
        abort       = 1'b0;
        sv20        = 1'b0;
        init20      = 1'b1;
        hold20      = 1'b0;
        abort20     = 1'b0;

        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(start_ready), 1);

        // Single block, then chained init=0 blocks, then a restart.
        run_block(1'b1, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        run_block(1'b0, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        run_block(1'b0, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        run_block(1'b1, 0, -1, 0, -1, 1'b0, 1'b0, -1);

        // Five-cycle stall at round 20.
        run_block(1'b0, 0, 20, 5, -1, 1'b0, 1'b0, -1);

        // Abort in ROUND at index 40, then in FINAL.
        run_block(1'b0, 0, -1, 0, 40, 1'b0, 1'b0, -1);
        run_block(1'b0, 20, -1, 0, -1, 1'b1, 1'b0, -1);

        // Start together with abort in IDLE is accepted.
        run_block(1'b0, 10, -1, 0, -1, 1'b0, 1'b1, -1);

        // Randomised blocks with stalls and occasional aborts.
        for (int i = 0; i < 6; i++) begin
            run_block(1'($urandom_range(1, 0)), 25, -1, 0,
                      ($urandom_range(3, 0) == 0) ? int'($urandom_range(NR - 1, 0)) : -1,
                      1'b0, 1'b0, -1);
        end

        // Reset mid-block at index 30, then a chained block from reset.
        run_block(1'b0, 0, -1, 0, -1, 1'b0, 1'b0, 30);
        run_block(1'b0, 0, -1, 0, -1, 1'b0, 1'b0, -1);

        // NUM_ROUNDS=20 instance against a fixed timeline.
        @(negedge clk);
        sv20 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            sv20 = 1'b0;
            #1;
            check("p20_ld",    32'(ld20), 32'(c == 1));
            check("p20_en",    32'(en20), 32'(c >= 2 && c <= 21));
            check("p20_idx",   32'(idx20), (c >= 2 && c <= 21) ? 32'(c - 2) : 0);
            check("p20_last",  32'(last20), 32'(c == 21));
            check("p20_wsel",  32'(wsel20), 32'(c >= 18 && c <= 21));
            check("p20_upd",   32'(upd20), 32'(c == 22));
            check("p20_done",  32'(done20), 32'(c == 23));
            check("p20_ready", 32'(sr20), 32'(c >= 24));
            check("p20_cnt",   32'(cnt20), 32'(c >= 23));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
